// File: rtl/multi_cycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// Optional feature macro PERF_CNT_EN is consumed by multi_cycle_ctrl.
package multi_cycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_LINK   = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // How the ALU operation is chosen in the current state.
    typedef enum logic [1:0] {
        CLS_ADD    = 2'd0,
        CLS_R      = 2'd1,
        CLS_I      = 2'd2,
        CLS_BRANCH = 2'd3
    } alu_cls_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [1:0] SRC1_OLDPC = 2'b00;
    localparam logic [1:0] SRC1_RS1   = 2'b01;
    localparam logic [1:0] SRC1_ZERO  = 2'b10;
    localparam logic [1:0] SRC1_PC    = 2'b11;

    localparam logic [1:0] SRC2_FOUR  = 2'b00;
    localparam logic [1:0] SRC2_IMM   = 2'b01;
    localparam logic [1:0] SRC2_RS2   = 2'b10;

    // SUB/SLT/SLTU leave zero for "equal"/"not less", so the sense flips per funct3.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic alu_zero);
        logic taken;
        case (funct3)
            3'b000:  taken = alu_zero;   // BEQ
            3'b001:  taken = !alu_zero;  // BNE
            3'b100:  taken = !alu_zero;  // BLT
            3'b101:  taken = alu_zero;   // BGE
            3'b110:  taken = !alu_zero;  // BLTU
            3'b111:  taken = alu_zero;   // BGEU
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_op_dec.sv
// ALU operation decoder: maps (operation class, funct3, funct7_b5) to alu_op_t.
// Used by multi_cycle_ctrl; no macro dependencies.
module alu_op_dec
    import multi_cycle_pkg::*;
(
    input  alu_cls_t   alu_cls,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output alu_op_t    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        unique case (alu_cls)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_R, CLS_I: begin
                case (funct3)
                    // Immediate forms have no SUB; bit 30 there is immediate data.
                    3'b000:  alu_op = (alu_cls == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            CLS_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        alu_op = ALU_SUB;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core (FETCH/DECODE/EXEC/MEM/LINK/WB).
// Define PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module multi_cycle_ctrl
    import multi_cycle_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic       pc_sel,
    output logic [1:0] alu_src1_sel,
    output logic [1:0] alu_src2_sel,
    output alu_op_t    alu_op,
    output logic       rf_we,
    output logic       wb_sel,
    output logic       illegal_insn,
    output logic [2:0] state_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_t   state_q, state_d;
    alu_cls_t alu_cls;
    alu_op_t  alu_op_raw;

    logic is_r, is_i, is_load, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, is_exec_class;

    assign is_r      = (opcode == OP_REG);
    assign is_i      = (opcode == OP_IMM);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);

    assign is_exec_class = is_r | is_i | is_load | is_store | is_branch |
                           is_jalr | is_lui | is_auipc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        alu_src1_sel = SRC1_OLDPC;
        alu_src2_sel = SRC2_FOUR;
        alu_cls      = CLS_ADD;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        illegal_insn = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    alu_src1_sel = SRC1_PC;
                    alu_src2_sel = SRC2_FOUR;
                    state_d      = S_DECODE;
                end
            end

            S_DECODE: begin
                // ALUOUT captures OLDPC+imm here as the branch/JAL target.
                alu_src1_sel = SRC1_OLDPC;
                alu_src2_sel = SRC2_IMM;
                if (is_jal) begin
                    state_d = S_LINK;
                end else if (is_exec_class) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_insn = 1'b1;
                    state_d      = S_FETCH;
                end
            end

            S_EXEC: begin
                state_d = S_FETCH;
                if (is_r) begin
                    alu_src1_sel = SRC1_RS1;
                    alu_src2_sel = SRC2_RS2;
                    alu_cls      = CLS_R;
                    state_d      = S_WB;
                end else if (is_i) begin
                    alu_src1_sel = SRC1_RS1;
                    alu_src2_sel = SRC2_IMM;
                    alu_cls      = CLS_I;
                    state_d      = S_WB;
                end else if (is_load || is_store) begin
                    alu_src1_sel = SRC1_RS1;
                    alu_src2_sel = SRC2_IMM;
                    state_d      = S_MEM;
                end else if (is_lui) begin
                    alu_src1_sel = SRC1_ZERO;
                    alu_src2_sel = SRC2_IMM;
                    state_d      = S_WB;
                end else if (is_auipc) begin
                    alu_src1_sel = SRC1_OLDPC;
                    alu_src2_sel = SRC2_IMM;
                    state_d      = S_WB;
                end else if (is_jalr) begin
                    alu_src1_sel = SRC1_RS1;
                    alu_src2_sel = SRC2_IMM;
                    state_d      = S_LINK;
                end else if (is_branch) begin
                    alu_src1_sel = SRC1_RS1;
                    alu_src2_sel = SRC2_RS2;
                    alu_cls      = CLS_BRANCH;
                    if (branch_taken(funct3, alu_zero)) begin
                        pc_we  = 1'b1;
                        pc_sel = 1'b1;
                    end
                end
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (mem_ready) begin
                    if (is_load) begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end

            S_LINK: begin
                // PC takes the target from ALUOUT while ALUOUT takes OLDPC+4 as link value.
                pc_we        = 1'b1;
                pc_sel       = 1'b1;
                alu_src1_sel = SRC1_OLDPC;
                alu_src2_sel = SRC2_FOUR;
                state_d      = S_WB;
            end

            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = is_load;
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            mdr_we       = 1'b0;
            pc_we        = 1'b0;
            pc_sel       = 1'b0;
            alu_src1_sel = 2'b00;
            alu_src2_sel = 2'b00;
            alu_cls      = CLS_ADD;
            rf_we        = 1'b0;
            wb_sel       = 1'b0;
            illegal_insn = 1'b0;
        end
    end

    alu_op_dec u_alu_op_dec (
        .alu_cls   (alu_cls),
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .alu_op    (alu_op_raw)
    );

    assign alu_op  = rst ? ALU_ADD : alu_op_raw;
    assign state_o = rst ? 3'b000 : state_q;

`ifdef PERF_CNT_EN
    logic        retire;
    logic [31:0] cycle_cnt_q, instret_cnt_q;

    assign retire = (state_q == S_WB) ||
                    (state_q == S_EXEC && is_branch) ||
                    (state_q == S_MEM && is_store && mem_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q   <= 32'd0;
            instret_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expected control vectors are queued by
// the stimulus process and checked by an independent monitor on the falling edge.
module tb_multi_cycle_ctrl;
    import multi_cycle_pkg::*;

    typedef struct packed {
        logic [2:0] state;
        logic       req;
        logic       we;
        logic       asel;
        logic       irwe;
        logic       mdrwe;
        logic       pcwe;
        logic       pcsel;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [3:0] op;
        logic       rfwe;
        logic       wbsel;
        logic       ill;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        alu_zero, mem_ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_sel;
    logic [1:0]  alu_src1_sel, alu_src2_sel;
    alu_op_t     alu_op;
    logic        rf_we, wb_sel, illegal_insn;
    logic [2:0]  state_o;

    ctl_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (ir[6:0]),
        .funct3       (ir[14:12]),
        .funct7_b5    (ir[30]),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_src1_sel (alu_src1_sel),
        .alu_src2_sel (alu_src2_sel),
        .alu_op       (alu_op),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .illegal_insn (illegal_insn),
        .state_o      (state_o)
    );

    function automatic ctl_t mk(input logic [2:0] st, input logic req, input logic we,
                                input logic asel, input logic irwe, input logic mdrwe,
                                input logic pcwe, input logic pcsel, input logic [1:0] s1,
                                input logic [1:0] s2, input logic [3:0] op,
                                input logic rfwe, input logic wbsel, input logic ill);
        ctl_t c;
        c = '{st, req, we, asel, irwe, mdrwe, pcwe, pcsel, s1, s2, op, rfwe, wbsel, ill};
        return c;
    endfunction

    // Monitor: every falling edge with a pending expectation is one comparison.
    initial begin
        ctl_t  e, a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = mk(state_o, mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, pc_sel,
                        alu_src1_sel, alu_src2_sel, alu_op, rf_we, wb_sel, illegal_insn);
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b (state,req,we,asel,irwe,mdrwe,pcwe,pcsel,s1,s2,op,rfwe,wbsel,ill)",
                             nm, a, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic step(input logic z, input logic rdy, input ctl_t e, input string nm);
        alu_zero  = z;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    ctl_t ZERO, F_OK, F_WAIT, D_OK, W_ALU, W_LD, L_OK;

    initial begin
        ZERO   = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0);
        F_OK   = mk(3'd0, 1, 0, 0, 1, 0, 1, 0, 2'd3, 2'd0, 4'd0, 0, 0, 0);
        F_WAIT = mk(3'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0);
        D_OK   = mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, 0, 0, 0);
        W_ALU  = mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 1, 0, 0);
        W_LD   = mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 1, 1, 0);
        L_OK   = mk(3'd4, 0, 0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 4'd0, 0, 0, 0);

        rst = 1'b1; ir = 32'h0; alu_zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(0, 1, ZERO, "reset_outputs_zero");
        rst = 1'b0;

        // add x3,x1,x2 with a fetch wait state first
        ir = 32'h002081B3;
        step(0, 0, F_WAIT, "add_fetch_wait");
        step(0, 1, F_OK, "add_fetch");
        step(0, 1, D_OK, "add_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd0, 0, 0, 0), "add_exec");
        step(0, 1, W_ALU, "add_wb");

        // sub x3,x1,x2
        ir = 32'h402081B3;
        step(0, 1, F_OK, "sub_fetch");
        step(0, 1, D_OK, "sub_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd1, 0, 0, 0), "sub_exec");
        step(0, 1, W_ALU, "sub_wb");

        // addi x1,x0,-1: bit 30 set but op stays ADD
        ir = 32'hFFF00093;
        step(0, 1, F_OK, "addi_fetch");
        step(0, 1, D_OK, "addi_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 0, 0, 0), "addi_exec");
        step(0, 1, W_ALU, "addi_wb");

        // srai x1,x1,3
        ir = 32'h4030D093;
        step(0, 1, F_OK, "srai_fetch");
        step(0, 1, D_OK, "srai_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd7, 0, 0, 0), "srai_exec");
        step(0, 1, W_ALU, "srai_wb");

        // lui x1,1
        ir = 32'h000010B7;
        step(0, 1, F_OK, "lui_fetch");
        step(0, 1, D_OK, "lui_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 4'd0, 0, 0, 0), "lui_exec");
        step(0, 1, W_ALU, "lui_wb");

        // lw x5,8(x1) with three MEM wait cycles
        ir = 32'h0080A283;
        step(0, 1, F_OK, "lw_fetch");
        step(0, 1, D_OK, "lw_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 0, 0, 0), "lw_exec");
        for (int i = 0; i < 3; i++)
            step(0, 0, mk(3'd3, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0), "lw_mem_wait");
        step(0, 1, mk(3'd3, 1, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0), "lw_mem_done");
        step(0, 1, W_LD, "lw_wb");

        // beq taken / not taken
        ir = 32'h00208463;
        step(0, 1, F_OK, "beq_t_fetch");
        step(0, 1, D_OK, "beq_t_decode");
        step(1, 1, mk(3'd2, 0, 0, 0, 0, 0, 1, 1, 2'd1, 2'd2, 4'd1, 0, 0, 0), "beq_taken_exec");
        step(0, 1, F_OK, "beq_nt_fetch");
        step(0, 1, D_OK, "beq_nt_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd1, 0, 0, 0), "beq_nottaken_exec");

        // blt taken on nonzero SLT result
        ir = 32'h0020C463;
        step(0, 1, F_OK, "blt_fetch");
        step(0, 1, D_OK, "blt_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 1, 1, 2'd1, 2'd2, 4'd3, 0, 0, 0), "blt_taken_exec");

        // bgeu not taken on nonzero SLTU result
        ir = 32'h0020F463;
        step(0, 1, F_OK, "bgeu_fetch");
        step(0, 1, D_OK, "bgeu_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 4'd4, 0, 0, 0), "bgeu_nt_exec");

        // jal x1,+16: no EXEC
        ir = 32'h010000EF;
        step(0, 1, F_OK, "jal_fetch");
        step(0, 1, D_OK, "jal_decode");
        step(0, 1, L_OK, "jal_link");
        step(0, 1, W_ALU, "jal_wb");

        // jalr x1,0(x1)
        ir = 32'h000080E7;
        step(0, 1, F_OK, "jalr_fetch");
        step(0, 1, D_OK, "jalr_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 0, 0, 0), "jalr_exec");
        step(0, 1, L_OK, "jalr_link");
        step(0, 1, W_ALU, "jalr_wb");

        // Illegal opcode 0x0B
        ir = 32'h0000000B;
        step(0, 1, F_OK, "ill_fetch");
        step(0, 1, mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 4'd0, 0, 0, 1), "ill_decode");

        // sw x2,8(x1) completing normally
        ir = 32'h0020A423;
        step(0, 1, F_OK, "sw_fetch");
        step(0, 1, D_OK, "sw_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 0, 0, 0), "sw_exec");
        step(0, 1, mk(3'd3, 1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0), "sw_mem_done");

        // sw interrupted by reset while waiting in MEM
        step(0, 1, F_OK, "sw2_fetch");
        step(0, 1, D_OK, "sw2_decode");
        step(0, 1, mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 4'd0, 0, 0, 0), "sw2_exec");
        step(0, 0, mk(3'd3, 1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 4'd0, 0, 0, 0), "sw2_mem_wait");
        rst = 1'b1;
        step(0, 1, ZERO, "rst_mid_mem");
        rst = 1'b0;
        ir = 32'h002081B3;
        step(0, 1, F_OK, "fetch_after_rst");
        step(0, 1, D_OK, "decode_after_rst");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
